// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared types for the intersection phase scheduler.
//   phase_e  : scheduler state, also driven out as the debug/phase output
//   light_e  : per-approach light code consumed by the pixel renderer
//   lights_t : highway/farm-road light pair
//   decode_lights() : phase -> light pair; the only place the light policy lives
package traffic_pkg;

    typedef enum logic [2:0] {
        AR_TO_H = 3'd0,
        HG      = 3'd1,
        HY      = 3'd2,
        AR_TO_F = 3'd3,
        FG      = 3'd4,
        FY      = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        L_RED = 2'd0,
        L_YEL = 2'd1,
        L_GRN = 2'd2
    } light_e;

    typedef struct packed {
        light_e hwy;
        light_e farm;
    } lights_t;

    // Every phase has at least one approach on RED, so the two lights can
    // never be non-RED at the same time.
    function automatic lights_t decode_lights(phase_e p);
        lights_t l;
        l.hwy  = L_RED;
        l.farm = L_RED;
        case (p)
            HG:      l.hwy  = L_GRN;
            HY:      l.hwy  = L_YEL;
            FG:      l.farm = L_GRN;
            FY:      l.farm = L_YEL;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (count <- RST_VAL)
//     load         load load_val this cycle (takes priority over counting)
//     load_val     value loaded, normally phase duration minus one
//     count        current count
//     zero         count == 0
module phase_timer #(
    parameter int          TW      = 6,
    parameter int unsigned RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] count,
    output logic          zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= TW'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler
//   Highway / farm-road intersection sequencer. The highway rests on green;
//   farm-road sensors raise a latched request that buys the farm road a green
//   of MIN_GRN..MAX_GRN cycles, extended while a car is still sensed.
//   One down-counter (phase_timer) times every phase.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     SN, SS       north/south farm-road car sensors (synchronous inputs)
//     phase        current phase (phase_e), registered
//     hwy_light    highway light code, registered with phase
//     farm_light   farm-road light code, registered with phase
//     farm_req     latched pending farm-road request
//     phase_start  one-cycle pulse on the first cycle of every new phase
//   Build option: SENSOR_DEBOUNCE_EN -- when defined each sensor is 2-flop
//   synchronised and must be stable DEB cycles before sense follows it;
//   otherwise sense is SN|SS registered once.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GRN = 8,
    parameter int MAX_GRN = 32,
    parameter int YEL     = 4,
    parameter int AR      = 2,
    parameter int TW      = 6,
    parameter int DEB     = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   SN,
    input  logic   SS,
    output phase_e phase,
    output light_e hwy_light,
    output light_e farm_light,
    output logic   farm_req,
    output logic   phase_start
);

    generate
        if ((MAX_GRN - 1 > (2**TW) - 1) || (MIN_GRN < 1) || (MAX_GRN < 1) ||
            (YEL < 1) || (AR < 1) || (DEB < 1) || (MIN_GRN > MAX_GRN)) begin : g_bad_cfg
            $error("phase_scheduler: illegal duration/timer-width configuration");
        end
    endgenerate

    // In FG the timer starts at MAX_GRN-1, so MIN_GRN cycles have elapsed
    // once it has fallen to MAX_GRN-MIN_GRN or below.
    localparam logic [TW-1:0] FG_MIN_DONE = TW'(MAX_GRN - MIN_GRN);

    logic          sense;
    logic [TW-1:0] timer_count;
    logic          timer_zero;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    phase_e        next_phase;
    logic          phase_chg;
    lights_t       next_lights;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int CW = $clog2(DEB + 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [CW-1:0] deb_cnt [2];

    // deb[i] follows sync2[i] only after DEB consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {SS, SN};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sense = |deb;
`else
    logic sense_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sense_q <= 1'b0;
        else        sense_q <= SN | SS;
    end

    assign sense = sense_q;
`endif

    function automatic logic [TW-1:0] dur_m1(phase_e p);
        case (p)
            HG:      return TW'(MIN_GRN - 1);
            HY, FY:  return TW'(YEL - 1);
            FG:      return TW'(MAX_GRN - 1);
            default: return TW'(AR - 1);
        endcase
    endfunction

    phase_timer #(
        .TW      (TW),
        .RST_VAL (AR - 1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .zero     (timer_zero)
    );

    always_comb begin
        next_phase = phase;
        case (phase)
            AR_TO_H: if (timer_zero)             next_phase = HG;
            HG:      if (timer_zero && farm_req) next_phase = HY;
            HY:      if (timer_zero)             next_phase = AR_TO_F;
            AR_TO_F: if (timer_zero)             next_phase = FG;
            FG:      if (timer_zero || ((timer_count <= FG_MIN_DONE) && !sense))
                                                 next_phase = FY;
            FY:      if (timer_zero)             next_phase = AR_TO_H;
            default:                             next_phase = AR_TO_H;
        endcase
        phase_chg   = (next_phase != phase);
        timer_load  = phase_chg;
        timer_val   = dur_m1(next_phase);
        next_lights = decode_lights(next_phase);
    end

    // Lights and phase_start are computed from next_phase so they change on
    // the same edge as phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= AR_TO_H;
            hwy_light   <= L_RED;
            farm_light  <= L_RED;
            farm_req    <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            phase       <= next_phase;
            hwy_light   <= next_lights.hwy;
            farm_light  <= next_lights.farm;
            phase_start <= phase_chg;
            // Entering FG consumes the request even if sense is high on that edge.
            if (phase_chg && (next_phase == FG)) begin
                farm_req <= 1'b0;
            end else if (sense && (phase != FG)) begin
                farm_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_scheduler.sv
module tb_phase_scheduler;

  localparam int MIN_GRN = 8;
  localparam int MAX_GRN = 32;
  localparam int YEL     = 4;
  localparam int AR      = 2;

  localparam logic [2:0] P_AR_TO_H = 3'd0;
  localparam logic [2:0] P_HG      = 3'd1;
  localparam logic [2:0] P_HY      = 3'd2;
  localparam logic [2:0] P_AR_TO_F = 3'd3;
  localparam logic [2:0] P_FG      = 3'd4;
  localparam logic [2:0] P_FY      = 3'd5;

  localparam logic [1:0] C_RED = 2'd0;
  localparam logic [1:0] C_YEL = 2'd1;
  localparam logic [1:0] C_GRN = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       sn;
  logic       ss;
  logic [2:0] phase_o;
  logic [1:0] hwy_o;
  logic [1:0] farm_o;
  logic       req_o;
  logic       start_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  phase_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SN          (sn),
    .SS          (ss),
    .phase       (phase_o),
    .hwy_light   (hwy_o),
    .farm_light  (farm_o),
    .farm_req    (req_o),
    .phase_start (start_o)
  );

  int n_checks = 0;
  int n_passed = 0;

  logic [8:0] exp_q[$];

  // ---------------- reference model (cycle counting) ----------------
  logic [2:0] m_phase;
  int         m_cnt;
  bit         m_req;
  bit         m_sense;
  bit         m_start;

  function automatic logic [1:0] exp_hwy(logic [2:0] p);
    if (p == P_HG) return C_GRN;
    if (p == P_HY) return C_YEL;
    return C_RED;
  endfunction

  function automatic logic [1:0] exp_farm(logic [2:0] p);
    if (p == P_FG) return C_GRN;
    if (p == P_FY) return C_YEL;
    return C_RED;
  endfunction

  task automatic model_reset();
    m_phase = P_AR_TO_H;
    m_cnt   = 1;
    m_req   = 1'b0;
    m_sense = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic model_step(input bit a, input bit b);
    logic [2:0] nxt;
    nxt = m_phase;
    case (m_phase)
      P_AR_TO_H: if (m_cnt >= AR) nxt = P_HG;
      P_HG:      if (m_cnt >= MIN_GRN && m_req) nxt = P_HY;
      P_HY:      if (m_cnt >= YEL) nxt = P_AR_TO_F;
      P_AR_TO_F: if (m_cnt >= AR) nxt = P_FG;
      P_FG:      if ((m_cnt >= MIN_GRN && !m_sense) || m_cnt >= MAX_GRN) nxt = P_FY;
      P_FY:      if (m_cnt >= YEL) nxt = P_AR_TO_H;
      default:   nxt = P_AR_TO_H;
    endcase
    if (nxt == P_FG && m_phase != P_FG) m_req = 1'b0;
    else if (m_sense && m_phase != P_FG) m_req = 1'b1;
    m_start = (nxt != m_phase);
    m_cnt   = m_start ? 1 : m_cnt + 1;
    m_phase = nxt;
    m_sense = a | b;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit a, input bit b);
    logic [8:0] got;
    sn = a;
    ss = b;
`ifndef SENSOR_DEBOUNCE_EN
    model_step(a, b);
    exp_q.push_back({m_phase, exp_hwy(m_phase), exp_farm(m_phase), m_req, m_start});
`endif
    @(posedge clk);
    @(negedge clk);
`ifndef SENSOR_DEBOUNCE_EN
    got = {phase_o, hwy_o, farm_o, req_o, start_o};
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check("cycle_outputs", 32'(got), 32'(exp_q.pop_front()));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_phase"}, 32'(phase_o), 32'(P_AR_TO_H));
    check({tag, "_hwy"},   32'(hwy_o),   32'(C_RED));
    check({tag, "_farm"},  32'(farm_o),  32'(C_RED));
    check({tag, "_req"},   32'(req_o),   32'd0);
    check({tag, "_start"}, 32'(start_o), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    bit         sn;
    bit         ss;
    int         ncyc;
    logic [2:0] exp_phase;
    bit         exp_req;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input string n, input bit a, input bit b, input int c,
                         input logic [2:0] p, input bit r);
    vec_t v;
    v.name = n; v.sn = a; v.ss = b; v.ncyc = c; v.exp_phase = p; v.exp_req = r;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sn    = 1'b0;
    ss    = 1'b0;
    model_reset();

    add_vec("rst_to_hg",      0, 0, 2,   P_HG,      0);
    add_vec("hg_rest_100",    0, 0, 100, P_HG,      0);
    add_vec("sn_pulse",       1, 0, 1,   P_HG,      0);
    add_vec("req_latched",    0, 0, 1,   P_HG,      1);
    add_vec("hy_entry",       0, 0, 1,   P_HY,      1);
    add_vec("hy_hold",        0, 0, 3,   P_HY,      1);
    add_vec("arf_entry",      0, 0, 1,   P_AR_TO_F, 1);
    add_vec("arf_hold",       0, 0, 1,   P_AR_TO_F, 1);
    add_vec("fg_entry",       0, 0, 1,   P_FG,      0);
    add_vec("fg_min_hold",    0, 0, 7,   P_FG,      0);
    add_vec("fy_after_min",   0, 0, 1,   P_FY,      0);
    add_vec("fy_hold",        0, 0, 3,   P_FY,      0);
    add_vec("arh_entry",      0, 0, 1,   P_AR_TO_H, 0);
    add_vec("arh_hold",       0, 0, 1,   P_AR_TO_H, 0);
    add_vec("hg_again",       0, 0, 1,   P_HG,      0);
    add_vec("hg_cycle3",      0, 0, 2,   P_HG,      0);
    add_vec("sn_pulse2",      1, 0, 1,   P_HG,      0);
    add_vec("req2",           0, 0, 1,   P_HG,      1);
    add_vec("hg_cycle8",      0, 0, 3,   P_HG,      1);
    add_vec("hy2_entry",      0, 0, 1,   P_HY,      1);
    add_vec("hy2_done",       0, 0, 4,   P_AR_TO_F, 1);
    add_vec("ss_on_arf",      0, 1, 2,   P_FG,      0);
    add_vec("fg_max_hold",    0, 1, 31,  P_FG,      0);
    add_vec("fy_at_max",      0, 0, 1,   P_FY,      0);
    add_vec("fy2_hold",       0, 0, 3,   P_FY,      0);
    add_vec("arh2_entry",     0, 0, 1,   P_AR_TO_H, 0);
    add_vec("hg3_entry",      0, 0, 2,   P_HG,      0);
    add_vec("sn3",            1, 0, 1,   P_HG,      0);
    add_vec("req3",           0, 0, 1,   P_HG,      1);
    add_vec("hg3_cycle8",     0, 0, 5,   P_HG,      1);
    add_vec("hy3_entry",      0, 0, 1,   P_HY,      1);
    add_vec("hy3_done",       0, 0, 4,   P_AR_TO_F, 1);
    add_vec("sn_pre_fg",      1, 0, 1,   P_AR_TO_F, 1);
    add_vec("fg_entry_clear", 0, 0, 1,   P_FG,      0);
    add_vec("fg3_hold",       0, 0, 7,   P_FG,      0);
    add_vec("fy3_no_rereq",   0, 0, 1,   P_FY,      0);
    add_vec("fy3_sn",         1, 0, 2,   P_FY,      1);

    // reset held: outputs at reset values
    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    rst_n = 1'b1;

`ifndef SENSOR_DEBOUNCE_EN
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].ncyc; c++) step(tbl[i].sn, tbl[i].ss);
      check({tbl[i].name, "_phase"}, 32'(phase_o), 32'(tbl[i].exp_phase));
      check({tbl[i].name, "_req"},   32'(req_o),   32'(tbl[i].exp_req));
    end

    // reset asserted mid-FY (FY cycle 3, request pending): immediate reset values
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_fy_reset");
    @(negedge clk);
    check_reset_state("mid_fy_held");
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_reset_hg", 32'(phase_o), 32'(P_HG));
    check("post_reset_start", 32'(start_o), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
`else
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("deb_hg", 32'(phase_o), 32'(P_HG));
    // a two-cycle sensor glitch must not reach farm_req
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0);
    check("deb_glitch_ignored", 32'(req_o), 32'd0);
    check("deb_glitch_phase", 32'(phase_o), 32'(P_HG));
    // a sustained press is accepted
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0);
    check("deb_press_req", 32'(req_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("deb_reset");
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
